// File: rtl/fifo_vr_typed_if.sv
`default_nettype none
//==============================================================================
// fifo_vr_typed_if : valid/ready handshake bundle for fifo_vr_typed
// Rev 1.0
//==============================================================================
interface fifo_vr_typed_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             i_clear;
  logic [WIDTH-1:0] i_in_data;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [WIDTH-1:0] o_out_data;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [CW-1:0]    o_count;
  logic             o_almostFull;

  modport master (
    output i_clear,
    output i_in_data,
    output i_in_valid,
    output i_out_ready,
    input  o_in_ready,
    input  o_out_data,
    input  o_out_valid,
    input  o_count,
    input  o_almostFull
  );

  modport slave (
    input  i_clear,
    input  i_in_data,
    input  i_in_valid,
    input  i_out_ready,
    output o_in_ready,
    output o_out_data,
    output o_out_valid,
    output o_count,
    output o_almostFull
  );
endinterface
`default_nettype wire

// File: rtl/fifo_vr_typed.sv
`default_nettype none
//==============================================================================
// fifo_vr_typed : single-clock first-word-fall-through FIFO, valid/ready both sides
// Rev 1.0
//==============================================================================
module fifo_vr_typed #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALMOST_FULL = 3,
  parameter bit          RESET_MEM   = 1'b0
) (
  input  wire logic           i_clk,
  input  wire logic           i_arst_n,
  fifo_vr_typed_if.slave      fifo_if
);

  localparam int unsigned     PW       = $clog2(DEPTH);
  localparam int unsigned     CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_LVL   = CW'(ALMOST_FULL);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_vr_typed: WIDTH must be >= 1");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_vr_typed: DEPTH must be a power of two and >= 2");
  end
  if ((ALMOST_FULL < 1) || (ALMOST_FULL > DEPTH)) begin : g_bad_af
    $error("fifo_vr_typed: ALMOST_FULL must be in 1..DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             almost_full_q, almost_full_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push_w;
  logic             pop_w;
  logic             wr_en_w;

  // Handshakes use only registered flags, so neither side sees a comb path from the other.
  assign push_w  = fifo_if.i_in_valid & in_ready_q;
  assign pop_w   = out_valid_q & fifo_if.i_out_ready;
  assign wr_en_w = push_w & ~fifo_if.i_clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fifo_if.i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
    in_ready_d    = (count_d != FULL_LVL);
    out_valid_d   = (count_d != '0);
    almost_full_d = (count_d >= AF_LVL);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      almost_full_q <= almost_full_d;
    end
  end

  if (RESET_MEM) begin : g_mem_rst
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_q[i] <= '0;
        end
      end else if (wr_en_w) begin
        mem_q[wr_ptr_q] <= fifo_if.i_in_data;
      end
    end
  end else begin : g_mem_norst
    always_ff @(posedge i_clk) begin
      if (wr_en_w) begin
        mem_q[wr_ptr_q] <= fifo_if.i_in_data;
      end
    end
  end

  assign fifo_if.o_in_ready   = in_ready_q;
  assign fifo_if.o_out_valid  = out_valid_q;
  assign fifo_if.o_out_data   = mem_q[rd_ptr_q];
  assign fifo_if.o_count      = count_q;
  assign fifo_if.o_almostFull = almost_full_q;

endmodule
`default_nettype wire
